// File: rtl/ack_peak_search.sv
// rtl/ack_peak_search.sv - per-channel best/second-best correlation peak tracker with record readout
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   clear               one-cycle pulse: drop stored peaks and start a new search
//   corr_complete       bin-done level; rising edge snapshots one result set
//   search_complete     search-done level; rising edge requests the report
//   sat_flat            NCH x 6-bit satellite IDs, channel k at [6k+5:6k]
//   integ_flat          NCH x INT_W integrator magnitudes
//   code_phase          code phase of the current bin
//   doppler_omega       Doppler of the current bin (passed through)
//   res_valid/res_ready record handshake
//   res_chan..res_doppler  record fields
//   busy                scan or report in progress
//   done                one-cycle pulse after the last record is accepted
//   overrun             sticky: a result set arrived while busy
module ack_peak_search #(
    parameter int NCH     = 8,
    parameter int INT_W   = 12,
    parameter int PHASE_W = 10,
    parameter int DOP_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 corr_complete,
    input  logic                 search_complete,
    input  logic [NCH*6-1:0]     sat_flat,
    input  logic [NCH*INT_W-1:0] integ_flat,
    input  logic [PHASE_W-1:0]   code_phase,
    input  logic [DOP_W-1:0]     doppler_omega,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2:0]           res_chan,
    output logic [5:0]           res_sat,
    output logic [INT_W-1:0]     res_peak,
    output logic [INT_W-1:0]     res_second,
    output logic [PHASE_W-1:0]   res_phase,
    output logic [DOP_W-1:0]     res_doppler,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [2:0] LAST = 3'(NCH - 1);

    state_t               state;
    logic                 prev_cc, prev_sc;
    logic                 cc_edge, sc_edge;
    logic                 pending;
    logic [2:0]           k_idx, r_idx, ld_idx;

    logic [NCH*6-1:0]     sh_sat;
    logic [NCH*INT_W-1:0] sh_integ;
    logic [PHASE_W-1:0]   sh_phase;
    logic [DOP_W-1:0]     sh_dop;

    logic [5:0]           sat_q    [NCH];
    logic [INT_W-1:0]     best_q   [NCH];
    logic [INT_W-1:0]     second_q [NCH];
    logic [PHASE_W-1:0]   phase_q  [NCH];
    logic [DOP_W-1:0]     dop_q    [NCH];

    logic [5:0]           cur_sat;
    logic [INT_W-1:0]     cur_integ;

    assign cc_edge = corr_complete & ~prev_cc;
    assign sc_edge = search_complete & ~prev_sc;
    assign busy    = (state != IDLE);

    // Channel currently being folded in from the snapshot.
    always_comb begin
        cur_sat   = '0;
        cur_integ = '0;
        for (int i = 0; i < NCH; i++) begin
            if (k_idx == 3'(i)) begin
                cur_sat   = sh_sat[6*i +: 6];
                cur_integ = sh_integ[INT_W*i +: INT_W];
            end
        end
    end

    // Record to load into the output registers: the next one while
    // reporting, record 0 when a report is about to start.
    always_comb begin
        ld_idx = '0;
        if (state == REPORT)
            ld_idx = r_idx + 3'd1;
    end

    // Edge detectors power up "high" so a level held across reset is not
    // mistaken for a fresh edge; clear deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_cc <= 1'b1;
            prev_sc <= 1'b1;
        end else begin
            prev_cc <= corr_complete;
            prev_sc <= search_complete;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            done        <= 1'b0;
            k_idx       <= '0;
            r_idx       <= '0;
            sh_sat      <= '0;
            sh_integ    <= '0;
            sh_phase    <= '0;
            sh_dop      <= '0;
            res_valid   <= 1'b0;
            res_chan    <= '0;
            res_sat     <= '0;
            res_peak    <= '0;
            res_second  <= '0;
            res_phase   <= '0;
            res_doppler <= '0;
            for (int i = 0; i < NCH; i++) begin
                sat_q[i]    <= '0;
                best_q[i]   <= '0;
                second_q[i] <= '0;
                phase_q[i]  <= '0;
                dop_q[i]    <= '0;
            end
        end else begin
            done <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                pending   <= 1'b0;
                overrun   <= 1'b0;
                k_idx     <= '0;
                r_idx     <= '0;
                res_valid <= 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    sat_q[i]    <= '0;
                    best_q[i]   <= '0;
                    second_q[i] <= '0;
                    phase_q[i]  <= '0;
                    dop_q[i]    <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (cc_edge) begin
                            sh_sat   <= sat_flat;
                            sh_integ <= integ_flat;
                            sh_phase <= code_phase;
                            sh_dop   <= doppler_omega;
                            k_idx    <= '0;
                            pending  <= sc_edge;
                            state    <= SCAN;
                        end else if (sc_edge) begin
                            r_idx       <= '0;
                            res_valid   <= 1'b1;
                            res_chan    <= ld_idx;
                            res_sat     <= sat_q[ld_idx];
                            res_peak    <= best_q[ld_idx];
                            res_second  <= second_q[ld_idx];
                            res_phase   <= phase_q[ld_idx];
                            res_doppler <= dop_q[ld_idx];
                            state       <= REPORT;
                        end
                    end

                    SCAN: begin
                        if (cc_edge)
                            overrun <= 1'b1;
                        if (sc_edge)
                            pending <= 1'b1;

                        // A new satellite on this channel restarts its history;
                        // strict compares make ties keep the earlier bin.
                        if (cur_sat != sat_q[k_idx]) begin
                            sat_q[k_idx]    <= cur_sat;
                            best_q[k_idx]   <= cur_integ;
                            second_q[k_idx] <= '0;
                            phase_q[k_idx]  <= sh_phase;
                            dop_q[k_idx]    <= sh_dop;
                        end else if (cur_integ > best_q[k_idx]) begin
                            second_q[k_idx] <= best_q[k_idx];
                            best_q[k_idx]   <= cur_integ;
                            phase_q[k_idx]  <= sh_phase;
                            dop_q[k_idx]    <= sh_dop;
                        end else if (cur_integ > second_q[k_idx]) begin
                            second_q[k_idx] <= cur_integ;
                        end

                        if (k_idx == LAST) begin
                            k_idx <= '0;
                            if (pending || sc_edge) begin
                                // Channel 0 is already final, so record 0 can
                                // be loaded while the last channel is updated.
                                pending     <= 1'b0;
                                r_idx       <= '0;
                                res_valid   <= 1'b1;
                                res_chan    <= ld_idx;
                                res_sat     <= sat_q[ld_idx];
                                res_peak    <= best_q[ld_idx];
                                res_second  <= second_q[ld_idx];
                                res_phase   <= phase_q[ld_idx];
                                res_doppler <= dop_q[ld_idx];
                                state       <= REPORT;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            k_idx <= k_idx + 3'd1;
                        end
                    end

                    REPORT: begin
                        if (cc_edge)
                            overrun <= 1'b1;
                        if (res_valid && res_ready) begin
                            if (r_idx == LAST) begin
                                res_valid <= 1'b0;
                                done      <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                r_idx       <= ld_idx;
                                res_chan    <= ld_idx;
                                res_sat     <= sat_q[ld_idx];
                                res_peak    <= best_q[ld_idx];
                                res_second  <= second_q[ld_idx];
                                res_phase   <= phase_q[ld_idx];
                                res_doppler <= dop_q[ld_idx];
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ack_peak_search.sv
// tb/tb_ack_peak_search.sv - randomized self-checking bench for ack_peak_search
module tb_ack_peak_search;
    localparam int NCH = 8;
    localparam int INT_W = 12;
    localparam int PHASE_W = 10;
    localparam int DOP_W = 16;
    localparam int REC_W = 3 + 6 + INT_W + INT_W + PHASE_W + DOP_W;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 clear = 1'b0;
    logic                 corr_complete = 1'b0;
    logic                 search_complete = 1'b0;
    logic [NCH*6-1:0]     sat_flat = '0;
    logic [NCH*INT_W-1:0] integ_flat = '0;
    logic [PHASE_W-1:0]   code_phase = '0;
    logic [DOP_W-1:0]     doppler_omega = '0;
    logic                 res_ready = 1'b0;
    logic                 res_valid;
    logic [2:0]           res_chan;
    logic [5:0]           res_sat;
    logic [INT_W-1:0]     res_peak;
    logic [INT_W-1:0]     res_second;
    logic [PHASE_W-1:0]   res_phase;
    logic [DOP_W-1:0]     res_doppler;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    ack_peak_search #(.NCH(NCH), .INT_W(INT_W), .PHASE_W(PHASE_W), .DOP_W(DOP_W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .corr_complete(corr_complete), .search_complete(search_complete),
        .sat_flat(sat_flat), .integ_flat(integ_flat),
        .code_phase(code_phase), .doppler_omega(doppler_omega),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_chan(res_chan), .res_sat(res_sat), .res_peak(res_peak),
        .res_second(res_second), .res_phase(res_phase), .res_doppler(res_doppler),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the host should learn about each channel.
    logic [5:0]         m_sat  [NCH];
    logic [INT_W-1:0]   m_best [NCH];
    logic [INT_W-1:0]   m_sec  [NCH];
    logic [PHASE_W-1:0] m_ph   [NCH];
    logic [DOP_W-1:0]   m_dop  [NCH];

    logic [5:0]         b_sat [NCH];
    logic [INT_W-1:0]   b_int [NCH];
    logic [REC_W-1:0]   got   [NCH];

    int lat, dones, stab, nacc;

    function automatic logic [REC_W-1:0] exp_rec(input int r);
        return {3'(r), m_sat[r], m_best[r], m_sec[r], m_ph[r], m_dop[r]};
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_sat[c] = '0; m_best[c] = '0; m_sec[c] = '0; m_ph[c] = '0; m_dop[c] = '0;
            b_sat[c] = '0; b_int[c] = '0;
        end
    endtask

    // Top-two tracking: new satellite restarts, strict improvements win.
    task automatic model_bin(input logic [PHASE_W-1:0] ph, input logic [DOP_W-1:0] dop);
        for (int c = 0; c < NCH; c++) begin
            if (b_sat[c] != m_sat[c]) begin
                m_sat[c] = b_sat[c]; m_best[c] = b_int[c]; m_sec[c] = '0;
                m_ph[c] = ph; m_dop[c] = dop;
            end else if (b_int[c] > m_best[c]) begin
                m_sec[c] = m_best[c]; m_best[c] = b_int[c]; m_ph[c] = ph; m_dop[c] = dop;
            end else if (b_int[c] > m_sec[c]) begin
                m_sec[c] = b_int[c];
            end
        end
    endtask

    task automatic drive_bin(input logic [PHASE_W-1:0] ph, input logic [DOP_W-1:0] dop);
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            sat_flat[6*c +: 6] = b_sat[c];
            integ_flat[INT_W*c +: INT_W] = b_int[c];
        end
        code_phase = ph;
        doppler_omega = dop;
        corr_complete = 1'b1;
        @(negedge clk);
        corr_complete = 1'b0;
        repeat (NCH) @(negedge clk);
        model_bin(ph, dop);
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_clear();
    endtask

    // mode 0: always ready; 1: stall 5 valid cycles then toggle; 2: random
    task automatic collect_report(input int mode);
        int stall_left, post;
        bit stalled, rdy;
        logic [REC_W-1:0] cur, held;
        lat = -1; dones = 0; stab = 0; nacc = 0;
        stalled = 1'b0; stall_left = 5; post = 0; held = '0;
        @(negedge clk); search_complete = 1'b1; res_ready = 1'b0;
        @(negedge clk); search_complete = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cur = {res_chan, res_sat, res_peak, res_second, res_phase, res_doppler};
            if (res_valid && lat < 0) lat = cyc + 1;
            if (done) dones++;
            if (res_valid && stalled && cur !== held) stab++;
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) begin
                if (res_valid && stall_left > 0) begin rdy = 1'b0; stall_left--; end
                else rdy = cyc[0];
            end else rdy = 1'($urandom_range(0, 1));
            if (res_valid && rdy) begin
                if (nacc < NCH) got[nacc] = cur;
                nacc++;
                stalled = 1'b0;
            end else stalled = res_valid;
            held = cur;
            res_ready = rdy;
            if (nacc >= NCH) begin
                post++;
                if (post > 3) break;
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({res_valid, done, busy, overrun} !== 4'b0) begin
            n_err++; $display("FAIL reset_flags got %b exp 0000", {res_valid, done, busy, overrun});
        end
        n_vec++;
        if ({res_chan, res_sat, res_peak, res_second, res_phase, res_doppler} !== '0) begin
            n_err++; $display("FAIL reset_fields got %h exp 0",
                {res_chan, res_sat, res_peak, res_second, res_phase, res_doppler});
        end
        model_clear();
    endtask

    task automatic test_single_bin();
        logic [REC_W-1:0] want;
        b_sat[0] = 6'd5; b_int[0] = 12'd100;
        drive_bin(10'd12, 16'hFED4);
        collect_report(0);
        n_vec++;
        if (lat !== 1) begin n_err++; $display("FAIL single_latency got %0d exp 1", lat); end
        want = {3'd0, 6'd5, 12'd100, 12'd0, 10'd12, 16'hFED4};
        n_vec++;
        if (got[0] !== want) begin n_err++; $display("FAIL single_rec0 got %h exp %h", got[0], want); end
        n_vec++;
        if (nacc !== NCH || dones !== 1) begin
            n_err++; $display("FAIL single_count got %0d recs %0d done exp 8 1", nacc, dones);
        end
        for (int r = 0; r < NCH; r++) begin
            n_vec++;
            if (got[r] !== exp_rec(r)) begin
                n_err++; $display("FAIL single_model rec%0d got %h exp %h", r, got[r], exp_rec(r));
            end
        end
    endtask

    task automatic test_ordering();
        logic [REC_W-1:0] want;
        int vals [3] = '{50, 90, 70};
        for (int i = 0; i < 3; i++) begin
            b_sat[3] = 6'd7; b_int[3] = 12'(vals[i]);
            drive_bin(10'(i + 1), 16'(100 * (i + 1)));
        end
        collect_report(0);
        want = {3'd3, 6'd7, 12'd90, 12'd70, 10'd2, 16'd200};
        n_vec++;
        if (got[3] !== want) begin n_err++; $display("FAIL order_rec3 got %h exp %h", got[3], want); end
        b_int[3] = 12'd90;
        drive_bin(10'd4, 16'd400);
        collect_report(0);
        n_vec++;
        if (got[3][DOP_W +: PHASE_W] !== 10'd2 || got[3][PHASE_W+DOP_W+INT_W +: INT_W] !== 12'd90) begin
            n_err++; $display("FAIL order_tie got %h exp phase 2 peak 90", got[3]);
        end
        for (int r = 0; r < NCH; r++) begin
            n_vec++;
            if (got[r] !== exp_rec(r)) begin
                n_err++; $display("FAIL order_model rec%0d got %h exp %h", r, got[r], exp_rec(r));
            end
        end
    endtask

    task automatic test_sat_change();
        logic [REC_W-1:0] want;
        b_sat[1] = 6'd4; b_int[1] = 12'd200;
        drive_bin(10'd77, 16'd5);
        b_sat[1] = 6'd9; b_int[1] = 12'd30;
        drive_bin(10'd78, 16'd6);
        collect_report(1);
        want = {3'd1, 6'd9, 12'd30, 12'd0, 10'd78, 16'd6};
        n_vec++;
        if (got[1] !== want) begin n_err++; $display("FAIL satchg_rec1 got %h exp %h", got[1], want); end
    endtask

    task automatic test_overrun();
        int cnt;
        for (int c = 0; c < NCH; c++) begin
            b_sat[c] = 6'(c + 20); b_int[c] = 12'($urandom_range(1, 4000));
        end
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            sat_flat[6*c +: 6] = b_sat[c]; integ_flat[INT_W*c +: INT_W] = b_int[c];
        end
        code_phase = 10'd300; doppler_omega = 16'h1234; corr_complete = 1'b1;
        @(negedge clk); corr_complete = 1'b0; cnt = int'(busy);
        @(negedge clk); cnt += int'(busy);
        @(negedge clk); cnt += int'(busy);
        sat_flat = ~sat_flat; integ_flat = ~integ_flat; code_phase = 10'd301; corr_complete = 1'b1;
        @(negedge clk); corr_complete = 1'b0; cnt += int'(busy);
        repeat (6) begin @(negedge clk); cnt += int'(busy); end
        model_bin(10'd300, 16'h1234);
        n_vec++;
        if (cnt !== NCH) begin n_err++; $display("FAIL overrun_busy got %0d exp %0d", cnt, NCH); end
        n_vec++;
        if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_flag got %b exp 1", overrun); end
        collect_report(0);
        for (int r = 0; r < NCH; r++) begin
            n_vec++;
            if (got[r] !== exp_rec(r)) begin
                n_err++; $display("FAIL overrun_model rec%0d got %h exp %h", r, got[r], exp_rec(r));
            end
        end
    endtask

    task automatic test_backpressure();
        collect_report(1);
        n_vec++;
        if (stab !== 0) begin n_err++; $display("FAIL bp_stable got %0d changes exp 0", stab); end
        n_vec++;
        if (nacc !== NCH || dones !== 1) begin
            n_err++; $display("FAIL bp_count got %0d recs %0d done exp 8 1", nacc, dones);
        end
        for (int r = 0; r < NCH; r++) begin
            n_vec++;
            if (got[r] !== exp_rec(r)) begin
                n_err++; $display("FAIL bp_model rec%0d got %h exp %h", r, got[r], exp_rec(r));
            end
        end
    endtask

    task automatic test_clear_reset();
        int w;
        @(negedge clk); search_complete = 1'b1;
        @(negedge clk); search_complete = 1'b0;
        w = 0;
        while (!res_valid && w < 10) begin @(negedge clk); w++; end
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_clear();
        n_vec++;
        if ({res_valid, busy, overrun} !== 3'b000) begin
            n_err++; $display("FAIL clear_drop got %b exp 000", {res_valid, busy, overrun});
        end
        for (int c = 0; c < NCH; c++) begin b_sat[c] = 6'(c + 1); b_int[c] = 12'd500; end
        for (int c = 0; c < NCH; c++) begin
            sat_flat[6*c +: 6] = b_sat[c]; integ_flat[INT_W*c +: INT_W] = b_int[c];
        end
        corr_complete = 1'b1;
        @(negedge clk); corr_complete = 1'b0;
        repeat (3) @(negedge clk);
        search_complete = 1'b1;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({res_valid, busy, overrun} !== 3'b000) begin
            n_err++; $display("FAIL rst_async got %b exp 000", {res_valid, busy, overrun});
        end
        @(negedge clk); rst = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_held_edge got %b exp 0", res_valid); end
        search_complete = 1'b0;
        for (int c = 0; c < NCH; c++) begin b_sat[c] = '0; b_int[c] = '0; end
        collect_report(0);
        for (int r = 0; r < NCH; r++) begin
            n_vec++;
            if (got[r] !== exp_rec(r)) begin
                n_err++; $display("FAIL rst_zero rec%0d got %h exp %h", r, got[r], exp_rec(r));
            end
        end
        n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun got %b exp 0", overrun); end
    endtask

    task automatic test_random();
        for (int round = 0; round < 3; round++) begin
            pulse_clear();
            for (int bin = 0; bin < 6; bin++) begin
                for (int c = 0; c < NCH; c++) begin
                    b_sat[c] = 6'($urandom_range(0, 2));
                    b_int[c] = 12'($urandom_range(0, 40));
                end
                drive_bin(10'($urandom), 16'($urandom));
            end
            collect_report(2);
            n_vec++;
            if (nacc !== NCH || dones !== 1) begin
                n_err++; $display("FAIL rand_count round%0d got %0d recs %0d done", round, nacc, dones);
            end
            for (int r = 0; r < NCH; r++) begin
                n_vec++;
                if (got[r] !== exp_rec(r)) begin
                    n_err++; $display("FAIL rand_model round%0d rec%0d got %h exp %h", round, r, got[r], exp_rec(r));
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_bin();
        test_ordering();
        test_sat_change();
        test_overrun();
        test_backpressure();
        test_clear_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
